ram_bus_arbiter: RTL and testbench
==================================

// Module: ram_bus_arbiter
// PURPOSE
//  Shares the single-port program/data RAM between two requesters: port 0 = cpu_v
//  (fetch/load/store/loadi/storei) and port 1 = a secondary master (video/debug DMA).
//  Grants one access at a time, drives RAM address/data/RW and returns read data.
//  Uses a req/ack handshake with round-robin fairness on contention.
//  Sits between both masters and the RAM; it is the only driver of the RAM bus.
// PARAMETERS
//  ADDR_W      16  RAM address width
//  DATA_W      16  RAM data width
//  RD_LATENCY  1   cycles from address valid to bus_RAM_DATA_OUT valid (1..7)
// PORTS
//  wire_clock        in   1       system clock; all logic on rising edge
//  wire_reset        in   1       synchronous reset, active-high
//  wire_req0         in   1       port 0 (CPU) request; held high until wire_ack0
//  wire_rw0          in   1       port 0: 1=write, 0=read; stable while req0 high
//  bus_addr0         in   ADDR_W  port 0 address; stable while req0 high
//  bus_wdata0        in   DATA_W  port 0 write data; stable while req0 high
//  wire_ack0         out  1       port 0 one-cycle completion pulse
//  wire_req1/wire_rw1/bus_addr1/bus_wdata1/wire_ack1: same, for port 1
//  bus_rdata         out  DATA_W  read data; valid in the cycle ack0/ack1 is high
//  bus_RAM_ADDRESS   out  ADDR_W  RAM address
//  bus_RAM_DATA_IN   out  DATA_W  RAM write data
//  wire_RW           out  1       RAM write enable, 1=write
//  bus_RAM_DATA_OUT  in   DATA_W  RAM read data
// BEHAVIOUR
//  - All outputs registered. Reset values: bus_RAM_ADDRESS=0, bus_RAM_DATA_IN=0,
//    wire_RW=0, wire_ack0=0, wire_ack1=0, bus_rdata=0, state=IDLE, last_grant=1.
//  - FSM: IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE: if any req high, pick winner, latch its addr/wdata/rw into RAM outputs,
//    load wait counter = RD_LATENCY, go ACCESS. No req: stay, wire_RW=0.
//  - Arbitration: one req -> that port. Both -> port != last_grant (round-robin);
//    last_grant=1 after reset, so CPU wins the first tie. last_grant updated on grant.
//  - ACCESS: RAM outputs held constant; wire_RW = latched rw. Counter decrements each
//    cycle; when counter==0: bus_rdata <= bus_RAM_DATA_OUT (reads only; writes leave
//    bus_rdata unchanged), wire_RW <= 0, assert winner's ack, go DONE.
//  - DONE: winner ack high exactly this one cycle; other ack stays 0; go IDLE.
//  - Timing: req seen in IDLE cycle N -> RAM bus driven N+1..N+1+RD_LATENCY ->
//    ack in cycle N+2+RD_LATENCY (N+3 at default). Next grant earliest in the
//    IDLE cycle after DONE; back-to-back throughput = one access per RD_LATENCY+3 cycles.
//  - Requester drops req in the cycle after its ack; req still high in IDLE is a new
//    request. req/addr/wdata/rw changes while granted are ignored (latched at grant).
//  - Request deasserted before ack (protocol violation): access completes anyway, ack
//    still pulses.
//  - wire_RW is never 1 in IDLE or DONE: exactly RD_LATENCY+1 write cycles per write.
//  - Reset mid-operation (any state): next edge forces all reset values, no ack
//    issued for the aborted access, in-flight write aborted (wire_RW=0).
//  - bus_RAM_ADDRESS/bus_RAM_DATA_IN keep last value in IDLE (no glitch to 0).
// TESTING
//  1 Reset: hold wire_reset 2 cycles -> all outputs 0, wire_RW=0, no ack.
//  2 CPU read: req0=1,rw0=0,addr0=16'h0010, RAM[10]=16'hC123 -> bus_RAM_ADDRESS=0010
//    from N+1, ack0 at N+3 with bus_rdata=C123, ack1 never high.
//  3 Port1 write: req1=1,rw1=1,addr1=16'h8000,wdata1=16'hBEEF -> wire_RW=1 exactly
//    2 cycles, RAM[8000]=BEEF afterwards, ack1 one pulse at N+3.
//  4 Contention: req0 and req1 held high continuously -> grants alternate 0,1,0,1,
//    acks every 4 cycles, port 0 first after reset.
//  5 Reset asserted during ACCESS of a write -> wire_RW=0 next cycle, no ack, next
//    tie after reset goes to port 0.
//  6 RD_LATENCY=3 build: read of addr 16'h0002 -> ack at N+5, data captured after 3
//    wait cycles; address stable for 4 cycles.

Source files
------------

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter
// ---------------
// Shares one single-port RAM between two masters. Port 0 is the CPU
// (fetch/load/store). Port 1 is a secondary master such as video or debug DMA.
// Only one access is on the RAM bus at a time. When both ports request,
// round-robin arbitration decides the winner. Each access runs through
// IDLE -> ACCESS -> DONE. The winner gets a one-cycle ack in DONE.
//
// Ports
//   wire_clock, wire_reset     clock, synchronous active-high reset
//   wire_reqN / wire_rwN       request (held until ack) and direction (1=write)
//   bus_addrN / bus_wdataN     address and write data; latched when the port is granted
//   wire_ackN                  one-cycle completion pulse
//   bus_rdata                  read data; valid while an ack is high
//   bus_RAM_ADDRESS/DATA_IN    RAM address and write data (registered)
//   wire_RW                    RAM write enable (registered, 1=write)
//   bus_RAM_DATA_OUT           RAM read data
module ram_bus_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              wire_clock,
  input  logic              wire_reset,
  input  logic              wire_req0,
  input  logic              wire_rw0,
  input  logic [ADDR_W-1:0] bus_addr0,
  input  logic [DATA_W-1:0] bus_wdata0,
  output logic              wire_ack0,
  input  logic              wire_req1,
  input  logic              wire_rw1,
  input  logic [ADDR_W-1:0] bus_addr1,
  input  logic [DATA_W-1:0] bus_wdata1,
  output logic              wire_ack1,
  output logic [DATA_W-1:0] bus_rdata,
  output logic [ADDR_W-1:0] bus_RAM_ADDRESS,
  output logic [DATA_W-1:0] bus_RAM_DATA_IN,
  output logic              wire_RW,
  input  logic [DATA_W-1:0] bus_RAM_DATA_OUT
);

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q;
  logic [2:0]          cnt_q;
  logic                last_grant_q;
  logic                winner_q;
  logic                rw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic                ack0_q;
  logic                ack1_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                any_req_d;
  logic                sel_d;
  logic                rw_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;

  // Grant selection: a lone requester always wins. On a tie the port that
  // was not granted last time wins. last_grant resets to 1, so the CPU
  // wins the first tie.
  always_comb begin
    any_req_d = wire_req0 | wire_req1;
    sel_d     = (wire_req0 && wire_req1) ? ~last_grant_q : wire_req1;
    rw_d      = sel_d ? wire_rw1   : wire_rw0;
    addr_d    = sel_d ? bus_addr1  : bus_addr0;
    wdata_d   = sel_d ? bus_wdata1 : bus_wdata0;
  end

  always_ff @(posedge wire_clock) begin
    if (wire_reset) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      last_grant_q <= 1'b1;
      winner_q     <= 1'b0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        // Stage: grant. Latch the winner's request onto the RAM bus.
        IDLE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          we_q   <= 1'b0;
          if (any_req_d) begin
            winner_q     <= sel_d;
            last_grant_q <= sel_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= rw_d;
            cnt_q        <= LAT;
            state_q      <= ACCESS;
          end
        end
        // Stage: access. The bus is held for RD_LATENCY+1 cycles. Read data
        // is captured on the final cycle.
        ACCESS: begin
          if (cnt_q == 3'd0) begin
            if (!rw_q) begin
              rdata_q <= bus_RAM_DATA_OUT;
            end
            we_q    <= 1'b0;
            ack0_q  <= ~winner_q;
            ack1_q  <= winner_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        // Stage: done. The ack is high for exactly this cycle.
        DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign wire_ack0       = ack0_q;
  assign wire_ack1       = ack1_q;
  assign bus_rdata       = rdata_q;
  assign bus_RAM_ADDRESS = addr_q;
  assign bus_RAM_DATA_IN = wdata_q;
  assign wire_RW         = we_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
module tb_ram_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, rw0, req1, rw1, ack0, ack1, rw;
  logic [15:0] addr0, wdata0, addr1, wdata1, rdata, ram_addr, ram_din, ram_dout;

  logic        l3_req0, l3_rw0, l3_req1, l3_rw1, l3_ack0, l3_ack1, l3_rw;
  logic [15:0] l3_addr0, l3_wdata0, l3_addr1, l3_wdata1, l3_rdata;
  logic [15:0] l3_ram_addr, l3_ram_din, l3_ram_dout;

  logic        pl_en;
  logic [15:0] pl_addr, pl_data;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        port;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  ram_bus_arbiter u_dut (
    .wire_clock(clk), .wire_reset(rst),
    .wire_req0(req0), .wire_rw0(rw0), .bus_addr0(addr0), .bus_wdata0(wdata0), .wire_ack0(ack0),
    .wire_req1(req1), .wire_rw1(rw1), .bus_addr1(addr1), .bus_wdata1(wdata1), .wire_ack1(ack1),
    .bus_rdata(rdata), .bus_RAM_ADDRESS(ram_addr), .bus_RAM_DATA_IN(ram_din),
    .wire_RW(rw), .bus_RAM_DATA_OUT(ram_dout)
  );

  ram_bus_arbiter #(.RD_LATENCY(3)) u_dut3 (
    .wire_clock(clk), .wire_reset(rst),
    .wire_req0(l3_req0), .wire_rw0(l3_rw0), .bus_addr0(l3_addr0), .bus_wdata0(l3_wdata0),
    .wire_ack0(l3_ack0),
    .wire_req1(l3_req1), .wire_rw1(l3_rw1), .bus_addr1(l3_addr1), .bus_wdata1(l3_wdata1),
    .wire_ack1(l3_ack1),
    .bus_rdata(l3_rdata), .bus_RAM_ADDRESS(l3_ram_addr), .bus_RAM_DATA_IN(l3_ram_din),
    .wire_RW(l3_rw), .bus_RAM_DATA_OUT(l3_ram_dout)
  );

  // RAM with one-cycle read latency for the default build
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (rw) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // RAM with three-cycle read latency for the RD_LATENCY=3 build
  logic [15:0] mem3 [0:65535];
  logic [15:0] p1, p2;
  always @(posedge clk) begin
    if (pl_en) mem3[pl_addr] <= pl_data;
    else if (l3_rw) mem3[l3_ram_addr] <= l3_ram_din;
    p1          <= mem3[l3_ram_addr];
    p2          <= p1;
    l3_ram_dout <= p2;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    cycle();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    checks++; if (ram_addr !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h want 0000", ram_addr); end
    checks++; if (ram_din !== 16'h0) begin errors++; $display("FAIL reset_din: got %h want 0000", ram_din); end
    checks++; if (rw !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b want 0", rw); end
    checks++; if ({ack0, ack1} !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", {ack0, ack1}); end
    checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
    checks++; if ({l3_ack0, l3_ack1, l3_rw} !== 3'b000) begin errors++; $display("FAIL reset_l3_ctrl: got %b want 000", {l3_ack0, l3_ack1, l3_rw}); end
  endtask

  task automatic test_cpu_read();
    exp_t e;
    int lat = 0;
    bit saw1 = 0;
    preload(16'h0010, 16'hC123);
    req0 = 1'b1; rw0 = 1'b0; addr0 = 16'h0010; wdata0 = 16'h0;
    sb.push_back('{port: 1'b0, data: 16'hC123});
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      cycle();
      if (ack1) saw1 = 1;
      if (i == 1) begin
        checks++; if (ram_addr !== 16'h0010) begin errors++; $display("FAIL cpu_read_addr: got %h want 0010", ram_addr); end
      end
      if (ack0) begin
        lat = i;
        req0 = 1'b0;
        e = sb.pop_front();
        checks++; if (rdata !== e.data) begin errors++; $display("FAIL cpu_read_data: got %h want %h", rdata, e.data); end
      end
    end
    checks++; if (lat != 3) begin errors++; $display("FAIL cpu_read_latency: got %0d want 3", lat); end
    checks++; if (saw1) begin errors++; $display("FAIL cpu_read_ack1: got 1 want 0"); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL cpu_read_sb: got %0d pending want 0", sb.size()); end
  endtask

  task automatic test_port1_write();
    exp_t e;
    int lat = 0;
    int rwcnt = 0;
    bit bad = 0;
    bit saw0 = 0;
    cycle();
    req1 = 1'b1; rw1 = 1'b1; addr1 = 16'h8000; wdata1 = 16'hBEEF;
    sb.push_back('{port: 1'b1, data: 16'hC123});  // writes leave rdata as it was
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      cycle();
      if (rw) begin
        rwcnt++;
        if (ram_addr !== 16'h8000 || ram_din !== 16'hBEEF) bad = 1;
      end
      if (ack0) saw0 = 1;
      if (ack1) begin
        lat = i;
        req1 = 1'b0;
        e = sb.pop_front();
        checks++; if (rdata !== e.data) begin errors++; $display("FAIL write_rdata_kept: got %h want %h", rdata, e.data); end
      end
    end
    cycle();
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL write_ack_pulse: got %b want 0", ack1); end
    checks++; if (lat != 3) begin errors++; $display("FAIL write_latency: got %0d want 3", lat); end
    checks++; if (rwcnt != 2) begin errors++; $display("FAIL write_rw_cycles: got %0d want 2", rwcnt); end
    checks++; if (bad) begin errors++; $display("FAIL write_bus: got wrong addr/data want 8000/BEEF"); end
    checks++; if (mem[16'h8000] !== 16'hBEEF) begin errors++; $display("FAIL write_ram: got %h want BEEF", mem[16'h8000]); end
    checks++; if (saw0) begin errors++; $display("FAIL write_ack0: got 1 want 0"); end
  endtask

  task automatic test_contention();
    exp_t e;
    int nacks = 0;
    int last_i = 0;
    bit both = 0;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    preload(16'h0100, 16'h1111);
    preload(16'h0200, 16'h2222);
    for (int k = 0; k < 4; k++)
      sb.push_back('{port: k[0], data: (k[0] ? 16'h2222 : 16'h1111)});
    req0 = 1'b1; rw0 = 1'b0; addr0 = 16'h0100;
    req1 = 1'b1; rw1 = 1'b0; addr1 = 16'h0200;
    for (int i = 1; i <= 40 && nacks < 4; i++) begin
      cycle();
      if (ack0 && ack1) both = 1;
      if (ack0 || ack1) begin
        nacks++;
        e = sb.pop_front();
        checks++; if (ack1 !== e.port) begin errors++; $display("FAIL tie_port[%0d]: got %b want %b", nacks, ack1, e.port); end
        checks++; if (rdata !== e.data) begin errors++; $display("FAIL tie_data[%0d]: got %h want %h", nacks, rdata, e.data); end
        checks++; if ((i - last_i) != ((nacks == 1) ? 3 : 4)) begin
          errors++; $display("FAIL tie_interval[%0d]: got %0d want %0d", nacks, i - last_i, (nacks == 1) ? 3 : 4);
        end
        last_i = i;
        if (nacks == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    checks++; if (nacks != 4) begin errors++; $display("FAIL tie_count: got %0d want 4", nacks); end
    checks++; if (both) begin errors++; $display("FAIL tie_both_acks: got 1 want 0"); end
  endtask

  task automatic test_reset_mid_write();
    exp_t e;
    int lat = 0;
    bit stray = 0;
    cycle();
    req0 = 1'b1; rw0 = 1'b1; addr0 = 16'h9000; wdata0 = 16'h1234;
    cycle();
    checks++; if (rw !== 1'b1) begin errors++; $display("FAIL abort_rw_active: got %b want 1", rw); end
    rst = 1'b1; req0 = 1'b0;
    cycle();
    rst = 1'b0;
    checks++; if (rw !== 1'b0) begin errors++; $display("FAIL abort_rw_cleared: got %b want 0", rw); end
    for (int i = 0; i < 4; i++) begin
      if (ack0 || ack1) stray = 1;
      cycle();
    end
    checks++; if (stray) begin errors++; $display("FAIL abort_no_ack: got ack want none"); end
    // last grant before reset was port 0, so only a reset-restored pointer lets port 0 win this tie
    sb.push_back('{port: 1'b0, data: 16'h1111});
    req0 = 1'b1; rw0 = 1'b0; addr0 = 16'h0100;
    req1 = 1'b1; rw1 = 1'b0; addr1 = 16'h0200;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      cycle();
      if (ack0 || ack1) begin
        lat = i;
        req0 = 1'b0; req1 = 1'b0;
        e = sb.pop_front();
        checks++; if (ack1 !== e.port) begin errors++; $display("FAIL abort_tie_port: got %b want %b", ack1, e.port); end
        checks++; if (rdata !== e.data) begin errors++; $display("FAIL abort_tie_data: got %h want %h", rdata, e.data); end
      end
    end
    checks++; if (lat != 3) begin errors++; $display("FAIL abort_tie_latency: got %0d want 3", lat); end
    cycle();
  endtask

  task automatic test_latency3();
    exp_t e;
    int lat = 0;
    int stable = 0;
    bit rwhigh = 0;
    preload(16'h0000, 16'h0BAD);
    preload(16'h0002, 16'hA5A5);
    for (int i = 0; i < 4; i++) cycle();
    sb.push_back('{port: 1'b0, data: 16'hA5A5});
    l3_req0 = 1'b1; l3_rw0 = 1'b0; l3_addr0 = 16'h0002;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      cycle();
      if (l3_rw) rwhigh = 1;
      if (l3_ack0 || l3_ack1) begin
        lat = i;
        l3_req0 = 1'b0;
        e = sb.pop_front();
        checks++; if (l3_rdata !== e.data) begin errors++; $display("FAIL lat3_data: got %h want %h", l3_rdata, e.data); end
        checks++; if (l3_ack0 !== 1'b1) begin errors++; $display("FAIL lat3_port: got ack0=%b want 1", l3_ack0); end
      end else if (l3_ram_addr === 16'h0002) begin
        stable++;
      end
    end
    checks++; if (lat != 5) begin errors++; $display("FAIL lat3_latency: got %0d want 5", lat); end
    checks++; if (stable != 4) begin errors++; $display("FAIL lat3_addr_stable: got %0d want 4", stable); end
    checks++; if (rwhigh) begin errors++; $display("FAIL lat3_rw: got 1 want 0"); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL final_sb: got %0d pending want 0", sb.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req0 = 1'b0; rw0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; rw1 = 1'b0; addr1 = '0; wdata1 = '0;
    l3_req0 = 1'b0; l3_rw0 = 1'b0; l3_addr0 = '0; l3_wdata0 = '0;
    l3_req1 = 1'b0; l3_rw1 = 1'b0; l3_addr1 = '0; l3_wdata1 = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    test_reset();
    test_cpu_read();
    test_port1_write();
    test_contention();
    test_reset_mid_write();
    test_latency3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
